// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier controller:
// state encoding and the step-counter width helper.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   // Wide enough to hold the values 0..width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Control bus between the multiplier controller (slave) and the
// requester/datapath side (master).
interface seq_mult_ctrl_if;

   logic start;
   logic q_lsb;
   logic busy;
   logic done;
   logic acc_clear;
   logic acc_load;
   logic acc_shift;
   logic q_load;
   logic q_shift;

   modport master (
      output start, q_lsb,
      input  busy, done, acc_clear, acc_load, acc_shift, q_load, q_shift
   );

   modport slave (
      input  start, q_lsb,
      output busy, done, acc_clear, acc_load, acc_shift, q_load, q_shift
   );

endinterface

// File: rtl/seq_mult_step_cnt.sv
// Step counter for the CALC phase: synchronous clear, count enable and a
// terminal-count flag raised when the count reaches WIDTH-1.
module seq_mult_step_cnt
   import seq_mult_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier controller: IDLE -> LOAD -> CALC (WIDTH cycles) -> DONE.
// Optional build macro SEQ_MULT_CTRL_ABORT_EN adds an abort input.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
`ifdef SEQ_MULT_CTRL_ABORT_EN
   input  logic           abort,
`endif
   seq_mult_ctrl_if.slave bus
);

   state_t r_state;
   state_t w_next;

   logic w_abort;
   logic w_cnt_clr;
   logic w_cnt_en;
   logic w_cnt_tc;
   logic w_busy;
   logic w_done;
   logic w_acc_clear;
   logic w_acc_load;
   logic w_acc_shift;
   logic w_q_load;
   logic w_q_shift;

`ifdef SEQ_MULT_CTRL_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   seq_mult_step_cnt #(
      .WIDTH (WIDTH)
   ) u_step_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .o_tc  (w_cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_acc_clear = 1'b0;
      w_acc_load  = 1'b0;
      w_acc_shift = 1'b0;
      w_q_load    = 1'b0;
      w_q_shift   = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next = LOAD;
            end
         end

         LOAD: begin
            w_busy      = 1'b1;
            w_acc_clear = 1'b1;
            if (w_abort) begin
               w_next = IDLE;
            end else begin
               w_q_load  = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = CALC;
            end
         end

         CALC: begin
            w_busy = 1'b1;
            if (w_abort) begin
               w_acc_clear = 1'b1;
               w_next      = IDLE;
            end else begin
               // Load and shift together means add-then-shift in the datapath.
               w_acc_load  = bus.q_lsb;
               w_acc_shift = 1'b1;
               w_q_shift   = 1'b1;
               w_cnt_en    = 1'b1;
               if (w_cnt_tc) begin
                  w_next = DONE;
               end
            end
         end

         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end

         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.acc_clear = w_acc_clear;
   assign bus.acc_load  = w_acc_load;
   assign bus.acc_shift = w_acc_shift;
   assign bus.q_load    = w_q_load;
   assign bus.q_shift   = w_q_shift;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl with a 4-bit shift-add datapath; products are
// queued when a multiply is requested and checked when done pulses.
module tb_seq_mult_ctrl;

   localparam int WIDTH = 4;

   localparam logic [6:0] C_IDLE  = 7'b0000000;
   localparam logic [6:0] C_LOAD  = 7'b1010010;
   localparam logic [6:0] C_DONE  = 7'b0100000;
   localparam logic [6:0] C_ABORT = 7'b1010000;

   logic clk;
   logic rst;
   logic start;
`ifdef SEQ_MULT_CTRL_ABORT_EN
   logic abort;
`endif

   seq_mult_ctrl_if bus ();

   seq_mult_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef SEQ_MULT_CTRL_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   // Datapath: accumulator, multiplier and multiplicand registers.
   logic [3:0] a_in;
   logic [3:0] b_in;
   logic [3:0] r_acc;
   logic [3:0] r_q;
   logic [3:0] r_m;
   logic [4:0] w_sum;

   assign w_sum     = {1'b0, r_acc} + (bus.acc_load ? {1'b0, r_m} : 5'd0);
   assign bus.start = start;
   assign bus.q_lsb = r_q[0];

   always @(posedge clk) begin
      if (bus.acc_clear) r_acc <= 4'd0;
      if (bus.q_load) begin
         r_q <= b_in;
         r_m <= a_in;
      end
      if (bus.acc_shift) r_acc <= w_sum[4:1];
      if (bus.q_shift)   r_q   <= {w_sum[0], r_q[3:1]};
   end

   // Ordered {busy, done, acc_clear, acc_load, acc_shift, q_load, q_shift}.
   logic [6:0] ctrl;
   assign ctrl = {bus.busy, bus.done, bus.acc_clear, bus.acc_load,
                  bus.acc_shift, bus.q_load, bus.q_shift};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("done_without_request", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("product", {24'd0, r_acc, r_q}, {24'd0, e});
         end
      end
   endtask

   initial begin
      logic [3:0] bits;
      int d0;
      int busy_n;

      rst   = 1'b1;
      start = 1'b0;
      a_in  = 4'd0;
      b_in  = 4'd0;
`ifdef SEQ_MULT_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      step();
      step();
      chk("reset_ctrl", ctrl, C_IDLE);
      rst = 1'b0;
      step();
      chk("idle_ctrl", ctrl, C_IDLE);

      // 13 * 11 with cycle-by-cycle timing
      a_in = 4'd13; b_in = 4'd11; start = 1'b1;
      exp_q.push_back(8'd143);
      step();
      start = 1'b0;
      chk("t1_load", ctrl, C_LOAD);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_calc", {ctrl[6:4], ctrl[2:0]}, 6'b100101);
      end
      step();
      chk("t1_done", ctrl, C_DONE);
      step();
      chk("t1_idle", ctrl, C_IDLE);

      // acc_load follows q_lsb 1,0,1,1
      bits = 4'b1101;
      a_in = 4'd5; b_in = bits; start = 1'b1;
      exp_q.push_back(8'd65);
      step();
      start = 1'b0;
      chk("t2_load", ctrl, C_LOAD);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_calc_lsb", ctrl, {3'b100, bits[i], 3'b101});
      end
      step();
      chk("t2_done", ctrl, C_DONE);
      step();
      chk("t2_idle", ctrl, C_IDLE);

      // start re-asserted during CALC is ignored
      a_in = 4'd9; b_in = 4'd6; start = 1'b1;
      exp_q.push_back(8'd54);
      d0 = done_cnt;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 0) start = 1'b0;
         if (i == 2) start = 1'b1;
         if (i == 4) start = 1'b0;
         busy_n += int'(bus.busy);
      end
      chk("t3_busy_cycles", busy_n, 5);
      chk("t3_done_pulses", done_cnt - d0, 1);

      // reset in the third CALC cycle
      a_in = 4'd7; b_in = 4'd7; start = 1'b1;
      exp_q.push_back(8'd49);
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("t4_calc3", {ctrl[6:4], ctrl[2:0]}, 6'b100101);
      rst = 1'b1;
      step();
      chk("t4_reset_idle", ctrl, C_IDLE);
      exp_q.delete();
      rst = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 8; i++) step();
      chk("t4_no_done", done_cnt - d0, 0);
      chk("t4_still_idle", ctrl, C_IDLE);

      // start held high: back-to-back with one IDLE gap
      a_in = 4'd2; b_in = 4'd3; start = 1'b1;
      exp_q.push_back(8'd6);
      exp_q.push_back(8'd6);
      d0 = done_cnt;
      for (int i = 0; i < 14; i++) begin
         step();
         if (i == 5)  chk("t5_done1", ctrl, C_DONE);
         if (i == 6)  chk("t5_gap_idle", ctrl, C_IDLE);
         if (i == 7) begin
            chk("t5_load2", ctrl, C_LOAD);
            start = 1'b0;
         end
      end
      chk("t5_done_pulses", done_cnt - d0, 2);

`ifdef SEQ_MULT_CTRL_ABORT_EN
      // abort in the second CALC cycle, then a clean 15 * 15
      a_in = 4'd3; b_in = 4'd5; start = 1'b1;
      exp_q.push_back(8'd15);
      step();
      start = 1'b0;
      step();
      step();
      abort = 1'b1;
      #1;
      chk("t6_abort_ctrl", ctrl, C_ABORT);
      step();
      abort = 1'b0;
      chk("t6_abort_idle", ctrl, C_IDLE);
      exp_q.delete();
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) step();
      chk("t6_no_done", done_cnt - d0, 0);
      a_in = 4'd15; b_in = 4'd15; start = 1'b1;
      exp_q.push_back(8'd225);
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("t6_done_pulses", done_cnt - d0, 1);
`endif

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
